flashram_emulator: RTL

Parametrised successor to the single-configuration FlashRAM save controller. Emulates a FlashRAM save chip with configurable page, sector and chip geometry, ID words and memory bank. It adds programmable busy-time emulation and a completion interrupt. It sits between the cartridge-bus save decoder and the memory arbiter, and backs the save image at `i_save_address` in external memory.

---
 rtl/flashram_emulator.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/flashram_emulator.sv
// FlashRAM save-chip emulator: configurable page/sector/chip geometry,
// ID words, programmable busy time and a one-cycle completion interrupt.
module flashram_emulator #(
    parameter int          PAGE_WORDS   = 32,
    parameter int          SECTOR_PAGES = 128,
    parameter int          NUM_SECTORS  = 8,
    parameter logic [31:0] TYPE_ID      = 32'h1111_8001,
    parameter logic [31:0] MODEL_ID     = 32'h00C2_001D,
    parameter logic [3:0]  MEM_BANK     = 4'd1,
    parameter int          DELAY_W      = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [23:0]        i_save_address,
    input  logic [DELAY_W-1:0] i_write_delay,
    input  logic [DELAY_W-1:0] i_erase_delay,
    output logic               o_flashram_read_mode,
    output logic               o_irq,
    input  logic               i_request,
    input  logic               i_write,
    output logic               o_busy,
    output logic               o_ack,
    input  logic [14:0]        i_address,
    input  logic [31:0]        i_data,
    output logic [31:0]        o_data,
    output logic               o_mem_request,
    output logic               o_mem_write,
    input  logic               i_mem_busy,
    input  logic               i_mem_ack,
    output logic [3:0]         o_mem_bank,
    output logic [23:0]        o_mem_address,
    output logic [31:0]        o_mem_data,
    input  logic [31:0]        i_mem_data
);
    localparam int PW = $clog2(PAGE_WORDS);
    localparam int SP = $clog2(SECTOR_PAGES);
    localparam int PI = $clog2(SECTOR_PAGES * NUM_SECTORS);
    localparam int CW = PI + PW + 1;

    localparam logic [CW-1:0] PAGE_CNT   = CW'(PAGE_WORDS);
    localparam logic [CW-1:0] SECTOR_CNT = CW'(SECTOR_PAGES * PAGE_WORDS);
    localparam logic [CW-1:0] CHIP_CNT   = CW'(SECTOR_PAGES * NUM_SECTORS * PAGE_WORDS);
    localparam logic [PW:0]   LAST_ACK   = (PW + 1)'(PAGE_WORDS - 1);

    typedef enum logic [4:0] {
        MODE_STATUS = 5'b00001,
        MODE_ID     = 5'b00010,
        MODE_READ   = 5'b00100,
        MODE_ERASE  = 5'b01000,
        MODE_WRITE  = 5'b10000
    } mode_t;

    typedef enum logic [2:0] {
        EX_IDLE,
        EX_READ,
        EX_WRITE,
        EX_DELAY,
        EX_DONE
    } ex_state_t;

    mode_t              r_mode;
    ex_state_t          r_ex_state;
    ex_state_t          w_ex_next;
    logic               r_erase_done;
    logic               r_write_done;
    logic               r_erase_busy;
    logic               r_write_busy;
    logic               r_op_erase;
    logic               r_chip;
    logic [PI-1:0]      r_page;
    logic [DELAY_W-1:0] r_delay_cnt;
    logic [CW-1:0]      r_acc_cnt;
    logic [PW:0]        r_ack_cnt;
    logic               r_ack;
    logic [31:0]        r_data;
    logic               r_irq;
    logic               r_mem_request;
    logic               r_mem_write;
    logic [23:0]        r_mem_address;
    logic [31:0]        r_mem_data;
    logic [31:0]        r_buf [PAGE_WORDS];

    logic          w_cmd;
    logic          w_dat_wr;
    logic          w_rd;
    logic          w_idle;
    logic [7:0]    w_opcode;
    logic [PI-1:0] w_cmd_page;
    logic [PI-1:0] w_sector_page;
    logic          w_start_prog;
    logic          w_start_erase;
    logic          w_accept;
    logic          w_issue;
    logic [CW-1:0] w_total;
    logic          w_last_accept;
    logic          w_ack_en;
    logic          w_last_ack;
    logic [3:0]    w_status;
    logic [31:0]   w_rd_data;
    logic [23:0]   w_page_off;
    logic [23:0]   w_word_addr;
    logic          w_unused_addr;

    assign w_cmd         = i_request & i_write & i_address[14];
    assign w_dat_wr      = i_request & i_write & ~i_address[14];
    assign w_rd          = i_request & ~i_write;
    assign w_idle        = (r_ex_state == EX_IDLE);
    assign w_opcode      = i_data[31:24];
    assign w_cmd_page    = i_data[PI-1:0];
    assign w_sector_page = (w_cmd_page >> SP) << SP;
    assign w_start_prog  = w_cmd & w_idle & (w_opcode == 8'hA5) & (r_mode == MODE_WRITE);
    assign w_start_erase = w_cmd & w_idle & (w_opcode == 8'h78) & (r_mode == MODE_ERASE);
    assign w_unused_addr = ^i_address[13:PW];

    assign w_total       = r_op_erase ? (r_chip ? CHIP_CNT : SECTOR_CNT) : PAGE_CNT;
    assign w_accept      = r_mem_request & ~i_mem_busy;
    assign w_issue       = ~r_mem_request & (r_acc_cnt < w_total)
                         & ((r_ex_state == EX_READ) | (r_ex_state == EX_WRITE));
    assign w_last_accept = w_accept & (r_acc_cnt == w_total - CW'(1));
    assign w_ack_en      = i_mem_ack & (r_ex_state == EX_READ);
    assign w_last_ack    = w_ack_en & (r_ack_cnt == LAST_ACK);

    assign w_page_off  = 24'({r_page, {PW{1'b0}}});
    assign w_word_addr = i_save_address + w_page_off + 24'(r_acc_cnt);

    assign w_status = {r_erase_done, r_write_done, r_erase_busy, r_write_busy};

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_rd_data = {12'h0, w_status, 12'h0, w_status};
        if (r_mode == MODE_ID) begin
            w_rd_data = i_address[0] ? MODEL_ID : TYPE_ID;
        end else if (r_mode == MODE_WRITE) begin
            w_rd_data = r_buf[i_address[PW-1:0]];
        end
    end

    always_comb begin
        w_ex_next = r_ex_state;
        case (r_ex_state)
            EX_IDLE: begin
                if (w_start_prog)       w_ex_next = EX_READ;
                else if (w_start_erase) w_ex_next = EX_WRITE;
            end
            EX_READ:  if (w_last_ack)            w_ex_next = EX_WRITE;
            EX_WRITE: if (w_last_accept)         w_ex_next = EX_DELAY;
            EX_DELAY: if (r_delay_cnt == '0)     w_ex_next = EX_DONE;
            EX_DONE:                             w_ex_next = EX_IDLE;
            default:                             w_ex_next = EX_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ex_state <= EX_IDLE;
        end else begin
            r_ex_state <= w_ex_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mode        <= MODE_STATUS;
            r_erase_done  <= 1'b0;
            r_write_done  <= 1'b0;
            r_erase_busy  <= 1'b0;
            r_write_busy  <= 1'b0;
            r_op_erase    <= 1'b0;
            r_chip        <= 1'b0;
            r_page        <= '0;
            r_delay_cnt   <= '0;
            r_acc_cnt     <= '0;
            r_ack_cnt     <= '0;
            r_ack         <= 1'b0;
            r_data        <= '0;
            r_irq         <= 1'b0;
            r_mem_request <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
        end else begin
            r_ack <= i_request & ~(w_rd & (r_mode == MODE_READ));
            r_irq <= 1'b0;
            if (w_rd && r_mode != MODE_READ) r_data <= w_rd_data;

            // Starting an operation drops to STATUS so the host can poll busy/done.
            if (w_cmd && w_idle) begin
                case (w_opcode)
                    8'hD2: r_mode <= MODE_STATUS;
                    8'hE1: r_mode <= MODE_ID;
                    8'hF0: r_mode <= MODE_READ;
                    8'hB4: r_mode <= MODE_WRITE;
                    8'h4B: begin
                        r_mode <= MODE_ERASE;
                        r_chip <= 1'b0;
                        r_page <= w_sector_page;
                    end
                    8'h3C: begin
                        r_mode <= MODE_ERASE;
                        r_chip <= 1'b1;
                        r_page <= '0;
                    end
                    8'h78: if (w_start_erase) begin
                        r_mode       <= MODE_STATUS;
                        r_op_erase   <= 1'b1;
                        r_erase_busy <= 1'b1;
                        r_erase_done <= 1'b0;
                        r_delay_cnt  <= i_erase_delay;
                        r_acc_cnt    <= '0;
                        r_ack_cnt    <= '0;
                    end
                    8'hA5: if (w_start_prog) begin
                        r_mode       <= MODE_STATUS;
                        r_op_erase   <= 1'b0;
                        r_page       <= w_cmd_page;
                        r_write_busy <= 1'b1;
                        r_write_done <= 1'b0;
                        r_delay_cnt  <= i_write_delay;
                        r_acc_cnt    <= '0;
                        r_ack_cnt    <= '0;
                    end
                    default: ;
                endcase
            end

            if (w_dat_wr && r_mode == MODE_STATUS) begin
                r_erase_done <= r_erase_done & i_data[3];
                r_write_done <= r_write_done & i_data[1];
            end

            if (w_accept) begin
                r_mem_request <= 1'b0;
                r_acc_cnt     <= r_acc_cnt + CW'(1);
            end else if (w_issue) begin
                r_mem_request <= 1'b1;
                r_mem_write   <= (r_ex_state == EX_WRITE);
                r_mem_address <= w_word_addr;
                r_mem_data    <= r_op_erase ? 32'hFFFF_FFFF : r_buf[r_acc_cnt[PW-1:0]];
            end

            if (w_ack_en) r_ack_cnt <= r_ack_cnt + (PW + 1)'(1);
            if (w_last_ack) r_acc_cnt <= '0;

            if (r_ex_state == EX_DELAY && r_delay_cnt != '0) begin
                r_delay_cnt <= r_delay_cnt - DELAY_W'(1);
            end

            // Placed after the status-clear write so a same-cycle done-set wins.
            if (r_ex_state == EX_DONE) begin
                r_irq  <= 1'b1;
                r_mode <= MODE_STATUS;
                if (r_op_erase) begin
                    r_erase_busy <= 1'b0;
                    r_erase_done <= 1'b1;
                end else begin
                    r_write_busy <= 1'b0;
                    r_write_done <= 1'b1;
                end
            end
        end
    end

    // NOTE: the page buffer has no reset; its contents are undefined until written.
    always_ff @(posedge i_clk) begin
        if (w_ack_en) begin
            r_buf[r_ack_cnt[PW-1:0]] <= i_mem_data & r_buf[r_ack_cnt[PW-1:0]];
        end else if (w_dat_wr && r_mode == MODE_WRITE) begin
            r_buf[i_address[PW-1:0]] <= i_data;
        end
    end

    assign o_flashram_read_mode = (r_mode == MODE_READ);
    assign o_irq                = r_irq;
    assign o_busy               = 1'b0;
    assign o_ack                = r_ack;
    assign o_data               = r_data;
    assign o_mem_request        = r_mem_request;
    assign o_mem_write          = r_mem_write;
    assign o_mem_bank           = MEM_BANK;
    assign o_mem_address        = r_mem_address;
    assign o_mem_data           = r_mem_data;

endmodule
